// File: rtl/recon_io_arb.sv
// Two-master Avalon-MM arbiter in front of the single-cycle recon IO slave.
// Define RECON_IO_ARB_RR_EN for round-robin arbitration; default is fixed priority (m0 wins).
module recon_io_arb #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic                  m0_chipselect,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_waitrequest,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic                  m1_chipselect,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_waitrequest,
    output logic                  m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic                  s_chipselect,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_WIDTH-1:0] s_writedata,
    input  logic [DATA_WIDTH-1:0] s_readdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;

    logic [1:0]            state;
    logic                  grant;
    logic                  last_grant;
    logic                  rd_pend;
    logic                  req0;
    logic                  req1;
    logic                  next_grant;
    logic                  g_cs;
    logic                  g_rd;
    logic                  g_wr;
    logic                  g_req;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic                  issue;
    logic                  issue_rd;

    assign req0 = m0_chipselect & (m0_read | m0_write);
    assign req1 = m1_chipselect & (m1_read | m1_write);

`ifdef RECON_IO_ARB_RR_EN
    always_comb begin
        if (req0 && req1) begin
            next_grant = ~last_grant;
        end else begin
            next_grant = req1;
        end
    end

    logic unused_rd_pend;
    assign unused_rd_pend = rd_pend;
`else
    assign next_grant = ~req0;

    // last_grant is kept for parity with the round-robin build but not consulted here
    logic unused_state_bits;
    assign unused_state_bits = last_grant ^ rd_pend;
`endif

    assign g_cs    = grant ? m1_chipselect : m0_chipselect;
    assign g_rd    = grant ? m1_read       : m0_read;
    assign g_wr    = grant ? m1_write      : m0_write;
    assign g_addr  = grant ? m1_address    : m0_address;
    assign g_wdata = grant ? m1_writedata  : m0_writedata;
    assign g_req   = g_cs & (g_rd | g_wr);

    // A granted master that dropped its request issues nothing; read+write counts as a write
    assign issue    = (state == ISSUE) & g_req;
    assign issue_rd = issue & g_rd & ~g_wr;

    assign s_address    = g_addr;
    assign s_writedata  = g_wdata;
    assign s_chipselect = issue;
    assign s_read       = issue_rd;
    assign s_write      = issue & g_wr;

    assign m0_waitrequest = req0 & ~((state == ISSUE) & ~grant);
    assign m1_waitrequest = req1 & ~((state == ISSUE) & grant);

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            grant            <= 1'b0;
            last_grant       <= 1'b1;
            rd_pend          <= 1'b0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            m0_readdatavalid <= issue_rd & ~grant;
            m1_readdatavalid <= issue_rd & grant;
            rd_pend          <= issue_rd;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant <= next_grant;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    last_grant <= grant;
                    state      <= issue_rd ? RDWAIT : IDLE;
                end
                RDWAIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recon_io_arb.sv
// Scoreboard bench for recon_io_arb: slave-side strobes and read returns are checked
// against expectations queued when each master request is driven.
`timescale 1ns/1ps
module tb_recon_io_arb;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] m0_address,   m1_address;
    logic          m0_chipselect, m1_chipselect;
    logic          m0_read,      m1_read;
    logic          m0_write,     m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic [DW-1:0] m0_readdata,  m1_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] s_address;
    logic          s_chipselect, s_read, s_write;
    logic [DW-1:0] s_writedata;
    logic [DW-1:0] s_readdata;

    int checks = 0;
    int errors = 0;

    typedef struct { int m; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } sexp_t;
    typedef struct { int m; logic [DW-1:0] data; } rexp_t;

    sexp_t         slave_q[$];
    rexp_t         rd_q[$];
    sexp_t         mon_s;
    rexp_t         mon_r;
    logic [DW-1:0] exp_mem  [0:63];
    logic [DW-1:0] slave_mem[0:63];

    always #5 clk = ~clk;

    recon_io_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_chipselect(m0_chipselect), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_chipselect(m1_chipselect), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_read(s_read),
        .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata)
    );

    // IO slave: registered read data, valid the cycle after s_read
    always @(posedge clk) begin
        if (s_chipselect && s_write) slave_mem[s_address] <= s_writedata;
        if (s_chipselect && s_read)  s_readdata <= slave_mem[s_address];
    end

    always @(negedge clk) begin
        if (reset_n && (s_read || s_write)) begin
            checks++;
            if (slave_q.size() == 0) begin
                errors++;
                $display("FAIL slave_unexpected: got rd=%0b wr=%0b addr=%0h, required no transfer",
                         s_read, s_write, s_address);
            end else begin
                mon_s = slave_q.pop_front();
                if (s_chipselect !== 1'b1 || s_write !== mon_s.wr || s_read !== !mon_s.wr ||
                    s_address !== mon_s.addr || (mon_s.wr && s_writedata !== mon_s.data) ||
                    ((mon_s.m == 0) ? m0_waitrequest : m1_waitrequest) !== 1'b0) begin
                    errors++;
                    $display("FAIL slave_xfer: got cs=%0b rd=%0b wr=%0b addr=%0h data=%0h wr0=%0b wr1=%0b, required m%0d wr=%0b addr=%0h data=%0h",
                             s_chipselect, s_read, s_write, s_address, s_writedata,
                             m0_waitrequest, m1_waitrequest, mon_s.m, mon_s.wr, mon_s.addr, mon_s.data);
                end
            end
        end
        if (reset_n && (m0_readdatavalid || m1_readdatavalid)) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rdv_unexpected: got rdv0=%0b rdv1=%0b, required none",
                         m0_readdatavalid, m1_readdatavalid);
            end else begin
                mon_r = rd_q.pop_front();
                if (m0_readdatavalid !== (mon_r.m == 0) || m1_readdatavalid !== (mon_r.m == 1) ||
                    ((mon_r.m == 0) ? m0_readdata : m1_readdata) !== mon_r.data) begin
                    errors++;
                    $display("FAIL rd_return: got rdv0=%0b rdv1=%0b d0=%0h d1=%0h, required m%0d data=%0h",
                             m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata,
                             mon_r.m, mon_r.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_m(input int m, input logic cs, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 0) begin
            m0_chipselect = cs; m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
        end else begin
            m1_chipselect = cs; m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
        end
    endtask

    function automatic logic wreq(input int m);
        return (m == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    task automatic push_wr(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sexp_t se;
        se.m = m; se.wr = 1'b1; se.addr = a; se.data = d;
        slave_q.push_back(se);
        exp_mem[a] = d;
    endtask

    task automatic push_rd(input int m, input logic [AW-1:0] a);
        sexp_t se;
        rexp_t re;
        se.m = m; se.wr = 1'b0; se.addr = a; se.data = '0;
        slave_q.push_back(se);
        re.m = m; re.data = exp_mem[a];
        rd_q.push_back(re);
    endtask

    // Single master transfer: queue expectations, hold the request until accepted
    task automatic xfer(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int stall);
        @(posedge clk); #1;
        if (wr)      push_wr(m, a, d);
        else if (rd) push_rd(m, a);
        set_m(m, 1'b1, rd, wr, a, d);
        stall = 0;
        @(negedge clk);
        while (wreq(m) && stall < 20) begin
            stall++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        set_m(m, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [AW-1:0] c_addr(input int m, input int k);
        return AW'((m + 1) * 16 + k);
    endfunction

    function automatic logic [DW-1:0] c_data(input int m, input int k);
        return DW'(((m == 0) ? 32'h0000_A000 : 32'h0000_B000) + k);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_waitreq: got %0b %0b, required 0 0", m0_waitrequest, m1_waitrequest);
        end
        checks++;
        if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdv: got %0b %0b, required 0 0", m0_readdatavalid, m1_readdatavalid);
        end
        checks++;
        if (s_chipselect !== 1'b0 || s_read !== 1'b0 || s_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_slave_idle: got cs=%0b rd=%0b wr=%0b, required 0", s_chipselect, s_read, s_write);
        end
        set_m(0, 1'b1, 1'b0, 1'b1, 6'h3, 32'h1);
        repeat (2) @(negedge clk);
        checks++;
        if (s_write !== 1'b0 || m0_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: got s_write=%0b wr0=%0b, required 0 1", s_write, m0_waitrequest);
        end
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_write();
        int st;
        xfer(0, 1'b0, 1'b1, 6'h1, 32'h0000_00A5, st);
        checks++;
        if (st !== 1) begin
            errors++;
            $display("FAIL write_stall: got %0d, required 1", st);
        end
        @(negedge clk);
        checks++;
        if (s_write !== 1'b0 || s_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL write_single_cycle: got wr=%0b cs=%0b, required 0 0", s_write, s_chipselect);
        end
        xfer(0, 1'b1, 1'b0, 6'h1, '0, st);
        @(negedge clk);
        checks++;
        if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL write_readback: got rdv=%0b data=%0h, required 1 a5", m0_readdatavalid, m0_readdata);
        end
        xfer(0, 1'b0, 1'b1, 6'h2, 32'h0000_1234, st);
    endtask

    task automatic test_read();
        int st;
        xfer(1, 1'b1, 1'b0, 6'h2, '0, st);
        checks++;
        if (st !== 1) begin
            errors++;
            $display("FAIL read_stall: got %0d, required 1", st);
        end
        @(negedge clk);
        checks++;
        if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h0000_1234 || m0_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL read_latency: got rdv1=%0b d1=%0h rdv0=%0b, required 1 1234 0",
                     m1_readdatavalid, m1_readdata, m0_readdatavalid);
        end
        checks++;
        if (s_read !== 1'b0) begin
            errors++;
            $display("FAIL read_strobe_pulse: got s_read=%0b in RDWAIT, required 0", s_read);
        end
        @(negedge clk);
        checks++;
        if (m1_readdatavalid !== 1'b0 || m0_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL read_rdv_pulse: got %0b %0b, required 0 0", m0_readdatavalid, m1_readdatavalid);
        end
    endtask

    task automatic test_contention();
        int n0, n1, i0, i1, st0, st1, mx0, mx1, cyc, last0, acc1;
        bit a0, a1;
`ifdef RECON_IO_ARB_RR_EN
        n0 = 3; n1 = 3;
        for (int k = 0; k < 3; k++) begin
            push_wr(0, c_addr(0, k), c_data(0, k));
            push_wr(1, c_addr(1, k), c_data(1, k));
        end
`else
        n0 = 6; n1 = 1;
        for (int k = 0; k < 6; k++) push_wr(0, c_addr(0, k), c_data(0, k));
        push_wr(1, c_addr(1, 0), c_data(1, 0));
`endif
        i0 = 0; i1 = 0; st0 = 0; st1 = 0; mx0 = 0; mx1 = 0; cyc = 0; last0 = 0; acc1 = 0;
        @(posedge clk); #1;
        set_m(0, 1'b1, 1'b0, 1'b1, c_addr(0, 0), c_data(0, 0));
        set_m(1, 1'b1, 1'b0, 1'b1, c_addr(1, 0), c_data(1, 0));
        while ((i0 < n0 || i1 < n1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            a0 = (i0 < n0) && !m0_waitrequest;
            a1 = (i1 < n1) && !m1_waitrequest;
            if (i0 < n0) begin
                if (a0) begin
                    if (st0 > mx0) mx0 = st0;
                    st0 = 0;
                    last0 = cyc;
                end else st0++;
            end
            if (i1 < n1) begin
                if (a1) begin
                    if (st1 > mx1) mx1 = st1;
                    st1 = 0;
                    acc1 = cyc;
                end else st1++;
            end
`ifndef RECON_IO_ARB_RR_EN
            if (i0 < n0 && i1 < n1) begin
                checks++;
                if (m1_waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL fixed_m1_blocked: got wr1=%0b at cycle %0d, required 1", m1_waitrequest, cyc);
                end
            end
`endif
            @(posedge clk); #1;
            if (a0) begin
                i0++;
                if (i0 < n0) set_m(0, 1'b1, 1'b0, 1'b1, c_addr(0, i0), c_data(0, i0));
                else         set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
            end
            if (a1) begin
                i1++;
                if (i1 < n1) set_m(1, 1'b1, 1'b0, 1'b1, c_addr(1, i1), c_data(1, i1));
                else         set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
            end
        end
        checks++;
        if (i0 != n0 || i1 != n1 || slave_q.size() != 0) begin
            errors++;
            $display("FAIL contention_done: got %0d/%0d %0d/%0d pending=%0d, required all done",
                     i0, n0, i1, n1, slave_q.size());
        end
        checks++;
        if (mx0 > 3) begin
            errors++;
            $display("FAIL contention_m0_stall: got %0d, required <=3", mx0);
        end
        checks++;
        if (acc1 - last0 < 1 || acc1 - last0 > 2) begin
            errors++;
            $display("FAIL contention_m1_tail: got %0d cycles, required 1..2", acc1 - last0);
        end
`ifdef RECON_IO_ARB_RR_EN
        checks++;
        if (mx1 > 3) begin
            errors++;
            $display("FAIL contention_m1_stall: got %0d, required <=3", mx1);
        end
`else
        checks++;
        if (mx1 != 2 * n0 + 1) begin
            errors++;
            $display("FAIL fixed_m1_wait: got %0d, required %0d", mx1, 2 * n0 + 1);
        end
`endif
    endtask

    task automatic test_reset_rdwait();
        sexp_t se;
        int    st;
        @(posedge clk); #1;
        se.m = 0; se.wr = 1'b0; se.addr = 6'h1; se.data = '0;
        slave_q.push_back(se);
        set_m(0, 1'b1, 1'b1, 1'b0, 6'h1, '0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rst_issue: got wr0=%0b, required 0", m0_waitrequest);
        end
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (m0_readdatavalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_rdwait_entry: got rdv0=%0b, required 1", m0_readdatavalid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || s_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_read: got rdv0=%0b rdv1=%0b cs=%0b, required 0 0 0",
                     m0_readdatavalid, m1_readdatavalid, s_chipselect);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        xfer(0, 1'b1, 1'b0, 6'h1, '0, st);
        checks++;
        if (st !== 1) begin
            errors++;
            $display("FAIL rst_reissue_stall: got %0d, required 1", st);
        end
        @(negedge clk);
        checks++;
        if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL rst_reissue_data: got rdv=%0b data=%0h, required 1 a5", m0_readdatavalid, m0_readdata);
        end
    endtask

    task automatic test_read_write_both();
        int st;
        xfer(0, 1'b1, 1'b1, 6'h0, 32'h0000_FFFF, st);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (m0_readdatavalid !== 1'b0 || s_read !== 1'b0) begin
                errors++;
                $display("FAIL rw_no_read: got rdv0=%0b s_read=%0b, required 0 0", m0_readdatavalid, s_read);
            end
        end
        xfer(1, 1'b1, 1'b0, 6'h0, '0, st);
        @(negedge clk);
        checks++;
        if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL rw_readback: got rdv=%0b data=%0h, required 1 ffff", m1_readdatavalid, m1_readdata);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_reset_rdwait();
        test_read_write_both();
        repeat (3) @(negedge clk);
        checks++;
        if (slave_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d slave %0d read pending, required 0 0",
                     slave_q.size(), rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
